mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning cycles from request acceptance to resp_valid; legal range 1..15.
REQ-002 SHALL have parameter INIT_XOR, default 13'h0000, meaning the value XORed with the address to form each word's reset contents.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  cache miss/write-back request present.
REQ-006 req_write  input  1  1 = write-back, 0 = refill read.
REQ-007 req_addr  input  5  word address, 0..31.
REQ-008 req_wdata  input  13  write-back data.
REQ-009 req_ready  output  1  responder can accept a request.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  cache consumes the response.
REQ-012 resp_rdata  output  13  read data, or the stored data for a write acknowledge.
REQ-013 resp_write  output  1  echoes req_write of the request being answered.

Function
REQ-014 SHALL hold a 32x13 register-array memory.
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
- IDLE: req_ready = 1.
- WAIT: count down.
- RESP: resp_valid = 1.
REQ-016 SHALL accept a request in IDLE when req_valid = 1, then latch addr, wdata and write, load the counter with LATENCY-1, and go to WAIT.
REQ-017 SHALL, in WAIT with counter = 0, go to RESP; otherwise decrement the counter.
- Result: resp_valid asserts exactly LATENCY cycles after the acceptance edge.
REQ-018 SHALL perform the memory write on the WAIT->RESP transition for write requests.
- resp_rdata = written data.
REQ-019 SHALL, for read requests, drive resp_rdata with mem[addr] captured on the WAIT->RESP transition.
REQ-020 SHALL hold resp_valid, resp_rdata and resp_write stable in RESP until resp_ready = 1, then return to IDLE.
REQ-021 SHALL keep req_ready = 0 in WAIT and RESP.
- A request arriving in those states is not accepted and must be held by the initiator.
- The same-cycle RESP->IDLE edge does not accept a request; acceptance happens in IDLE on the next cycle.
REQ-022 SHALL drive resp_rdata = 0 whenever resp_valid = 0.
REQ-023 SHALL give a read to the address of the immediately preceding write the new data (no stale read).

Reset
REQ-024 SHALL, on reset = 1 at a rising edge:
- set state IDLE, counter 0, req_ready = 1 from the next cycle, resp_valid = 0, resp_rdata = 0, resp_write = 0;
- set every mem[i] = i XOR INIT_XOR, zero-extended to 13 bits.
REQ-025 SHALL abort an in-flight request on reset mid-WAIT/RESP.
- A pending write is discarded.
- No response is issued.

Configuration
REQ-026 SHALL, with MEM_RESPONDER_STATS_EN defined, add outputs rd_count[7:0] and wr_count[7:0].
- Each increments on the WAIT->RESP transition of a read/write respectively.
- Each saturates at 8'hFF and resets to 0.
REQ-027 SHALL, without MEM_RESPONDER_STATS_EN, omit those ports and counters entirely, with identical behaviour otherwise.

Structure
REQ-028 SHALL place in the shared package:
- the FSM state typedef (IDLE/WAIT/RESP);
- ADDR_W = 5, DATA_W = 13, DEPTH = 32.
REQ-029 SHALL keep the latency counter in a sub-module named lat_counter (load, decrement, zero flag); the memory array and FSM stay in mem_responder.

Verification
REQ-030 Reset, then read addr 5 (INIT_XOR = 0) -> resp_valid exactly 3 cycles after acceptance, resp_rdata = 13'd5, resp_write = 0.
REQ-031 Write addr 31 data 13'h1ABC, then read addr 31 -> write ack resp_rdata = 13'h1ABC; read returns 13'h1ABC.
REQ-032 Hold resp_ready = 0 for 5 cycles in RESP with req_valid = 1 -> response stable, req_ready = 0, no second request accepted; release -> IDLE, next request accepted one cycle later.
REQ-033 Assert reset during WAIT of a write to addr 2 data 13'h0FFF -> no resp_valid; a subsequent read of addr 2 returns 13'd2.
REQ-034 LATENCY = 1 back-to-back reads of addrs 0 and 1, resp_ready tied 1 -> resp_valid 1 cycle after each acceptance, data 0 then 1.
REQ-035 MEM_RESPONDER_STATS_EN defined: 300 reads, 2 writes -> rd_count = 8'hFF, wr_count = 8'd2; reset -> both 0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared widths, FSM state type and helpers for the mem_responder slice.
package mem_responder_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 13;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STAT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Reset contents of one word: zero-extended address XOR a fixed pattern.
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a,
                                                    input logic [DATA_W-1:0] x);
        return DATA_W'(a) ^ x;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a cache (master) and the memory responder (slave).
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_write;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_write
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_write
    );

endinterface

// File: rtl/mem_responder_lat_counter.sv
// Latency down-counter: loads on request acceptance, counts to zero while waiting.
module lat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for cache refills and write-backs.
// Optional read/write statistics counters are enabled by MEM_RESPONDER_STATS_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned       LATENCY  = 3,
    parameter logic [DATA_W-1:0] INIT_XOR = 13'h0000
) (
    input  logic              clock,
    input  logic              reset,
    mem_responder_if.slave    bus
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count
`endif
);

    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
        $error("mem_responder: LATENCY must be within 1..15");
    end

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_write;
    logic [DATA_W-1:0] r_resp_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_zero;
    logic              w_dec;
    logic              w_to_resp;

    assign w_accept  = (r_state == IDLE) && bus.req_valid;
    assign w_dec     = (r_state == WAIT) && !w_zero;
    assign w_to_resp = (r_state == WAIT) && w_zero;

    lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_load     (w_accept),
        .i_load_val (CNT_W'(LATENCY - 1)),
        .i_dec      (w_dec),
        .o_zero_c   (w_zero)
    );

    // FSM, memory array and registered bus outputs; reset aborts any in-flight request.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_write <= 1'b0;
            r_resp_rdata <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= init_word(ADDR_W'(i), INIT_XOR);
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_write     <= bus.req_write;
                        r_req_ready <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_zero) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_write <= r_write;
                        if (r_write) begin
                            r_mem[r_addr] <= r_wdata;
                            r_resp_rdata  <= r_wdata;
                        end else begin
                            r_resp_rdata  <= r_mem[r_addr];
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_write <= 1'b0;
                        r_resp_rdata <= '0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_write <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_write = r_resp_write;

`ifdef MEM_RESPONDER_STATS_EN
    logic [STAT_W-1:0] r_rd_count;
    logic [STAT_W-1:0] r_wr_count;

    // Saturating counts of completed reads and writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_to_resp) begin
            if (r_write) begin
                r_wr_count <= sat_inc(r_wr_count);
            end else begin
                r_rd_count <= sat_inc(r_rd_count);
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY 3 and LATENCY 1 instances).
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if b3 ();
    mem_responder_if b1 ();

`ifdef MEM_RESPONDER_STATS_EN
    logic [7:0] rd3, wr3, rd1, wr1;
`endif

    mem_responder #(.LATENCY(3), .INIT_XOR(13'h0000)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (b3)
`ifdef MEM_RESPONDER_STATS_EN
        , .rd_count (rd3), .wr_count (wr3)
`endif
    );

    mem_responder #(.LATENCY(1), .INIT_XOR(13'h0000)) dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (b1)
`ifdef MEM_RESPONDER_STATS_EN
        , .rd_count (rd1), .wr_count (wr1)
`endif
    );

    // Present one request to the LATENCY-3 instance; lat = cycles from acceptance to resp_valid, -1 on timeout.
    task automatic issue3(input logic w, input logic [4:0] a, input logic [12:0] d, output int lat);
        b3.req_valid = 1'b1;
        b3.req_write = w;
        b3.req_addr  = a;
        b3.req_wdata = d;
        @(negedge clk);
        b3.req_valid = 1'b0;
        lat = 0;
        while (b3.resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (b3.resp_valid !== 1'b1) lat = -1;
    endtask

    task automatic consume3();
        b3.resp_ready = 1'b1;
        @(negedge clk);
        b3.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b3.req_valid = 1'b0; b3.req_write = 1'b0; b3.req_addr = '0; b3.req_wdata = '0; b3.resp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; b1.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (b3.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", b3.req_ready); end
        n_checks++; if (b3.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", b3.resp_valid); end
        n_checks++; if (b3.resp_rdata !== 13'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h exp 0", b3.resp_rdata); end
        n_checks++; if (b3.resp_write !== 1'b0) begin n_fail++; $display("FAIL reset_resp_write got %b exp 0", b3.resp_write); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (b3.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready got %b exp 1", b3.req_ready); end
    endtask

    task automatic test_read_init();
        int lat;
        issue3(1'b0, 5'd5, 13'h0, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read5_latency got %0d exp 3", lat); end
        n_checks++; if (b3.resp_rdata !== 13'd5) begin n_fail++; $display("FAIL read5_rdata got %h exp %h", b3.resp_rdata, 13'd5); end
        n_checks++; if (b3.resp_write !== 1'b0) begin n_fail++; $display("FAIL read5_write got %b exp 0", b3.resp_write); end
        consume3();
        n_checks++; if (b3.resp_valid !== 1'b0) begin n_fail++; $display("FAIL read5_done_valid got %b exp 0", b3.resp_valid); end
        n_checks++; if (b3.resp_rdata !== 13'h0) begin n_fail++; $display("FAIL read5_idle_rdata got %h exp 0", b3.resp_rdata); end
        n_checks++; if (b3.req_ready !== 1'b1) begin n_fail++; $display("FAIL read5_idle_ready got %b exp 1", b3.req_ready); end
    endtask

    task automatic test_write_read();
        int lat;
        issue3(1'b1, 5'd31, 13'h1ABC, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr31_latency got %0d exp 3", lat); end
        n_checks++; if (b3.resp_rdata !== 13'h1ABC) begin n_fail++; $display("FAIL wr31_ack_rdata got %h exp 1abc", b3.resp_rdata); end
        n_checks++; if (b3.resp_write !== 1'b1) begin n_fail++; $display("FAIL wr31_ack_write got %b exp 1", b3.resp_write); end
        consume3();
        issue3(1'b0, 5'd31, 13'h0, lat);
        n_checks++; if (b3.resp_rdata !== 13'h1ABC) begin n_fail++; $display("FAIL rd31_rdata got %h exp 1abc", b3.resp_rdata); end
        n_checks++; if (b3.resp_write !== 1'b0) begin n_fail++; $display("FAIL rd31_write got %b exp 0", b3.resp_write); end
        consume3();
        issue3(1'b0, 5'd30, 13'h0, lat);
        n_checks++; if (b3.resp_rdata !== 13'd30) begin n_fail++; $display("FAIL rd30_rdata got %h exp %h", b3.resp_rdata, 13'd30); end
        consume3();
    endtask

    task automatic test_backpressure();
        int lat;
        issue3(1'b0, 5'd7, 13'h0, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency got %0d exp 3", lat); end
        b3.req_valid = 1'b1; b3.req_write = 1'b0; b3.req_addr = 5'd9;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (b3.resp_valid !== 1'b1 || b3.resp_rdata !== 13'd7 || b3.resp_write !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold cycle %0d got v=%b d=%h w=%b exp v=1 d=0007 w=0", k, b3.resp_valid, b3.resp_rdata, b3.resp_write); end
            n_checks++; if (b3.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready cycle %0d got %b exp 0", k, b3.req_ready); end
        end
        consume3();
        n_checks++; if (b3.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b exp 0", b3.resp_valid); end
        n_checks++; if (b3.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", b3.req_ready); end
        @(negedge clk);
        n_checks++; if (b3.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept got %b exp 0", b3.req_ready); end
        b3.req_valid = 1'b0;
        lat = 0;
        while (b3.resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp_second_latency got %0d exp 3", lat); end
        n_checks++; if (b3.resp_rdata !== 13'd9) begin n_fail++; $display("FAIL bp_second_rdata got %h exp %h", b3.resp_rdata, 13'd9); end
        consume3();
    endtask

    task automatic test_reset_abort();
        int lat;
        logic seen;
        b3.req_valid = 1'b1; b3.req_write = 1'b1; b3.req_addr = 5'd2; b3.req_wdata = 13'h0FFF;
        @(negedge clk);
        b3.req_valid = 1'b0;
        n_checks++; if (b3.req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_accept got %b exp 0", b3.req_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (b3.req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b exp 1", b3.req_ready); end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (b3.resp_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_resp got %b exp 0", seen); end
        issue3(1'b0, 5'd2, 13'h0, lat);
        n_checks++; if (b3.resp_rdata !== 13'd2) begin n_fail++; $display("FAIL abort_read2 got %h exp %h", b3.resp_rdata, 13'd2); end
        consume3();
    endtask

    task automatic test_back_to_back();
        b1.resp_ready = 1'b1;
        b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = 5'd0; b1.req_wdata = '0;
        @(negedge clk);
        n_checks++; if (b1.req_ready !== 1'b0 || b1.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_accept0 got r=%b v=%b exp r=0 v=0", b1.req_ready, b1.resp_valid); end
        b1.req_addr = 5'd1;
        @(negedge clk);
        n_checks++; if (b1.resp_valid !== 1'b1 || b1.resp_rdata !== 13'd0) begin n_fail++; $display("FAIL b2b_resp0 got v=%b d=%h exp v=1 d=0000", b1.resp_valid, b1.resp_rdata); end
        @(negedge clk);
        n_checks++; if (b1.resp_valid !== 1'b0 || b1.resp_rdata !== 13'd0 || b1.req_ready !== 1'b1)
            begin n_fail++; $display("FAIL b2b_idle got v=%b d=%h r=%b exp v=0 d=0000 r=1", b1.resp_valid, b1.resp_rdata, b1.req_ready); end
        @(negedge clk);
        b1.req_valid = 1'b0;
        n_checks++; if (b1.req_ready !== 1'b0 || b1.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_accept1 got r=%b v=%b exp r=0 v=0", b1.req_ready, b1.resp_valid); end
        @(negedge clk);
        n_checks++; if (b1.resp_valid !== 1'b1 || b1.resp_rdata !== 13'd1) begin n_fail++; $display("FAIL b2b_resp1 got v=%b d=%h exp v=1 d=0001", b1.resp_valid, b1.resp_rdata); end
        @(negedge clk);
        n_checks++; if (b1.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done got %b exp 0", b1.resp_valid); end
    endtask

`ifdef MEM_RESPONDER_STATS_EN
    task automatic test_stats();
        int n_bad;
        int lat;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (rd1 !== 8'h00 || wr1 !== 8'h00) begin n_fail++; $display("FAIL stats_init got rd=%h wr=%h exp 00 00", rd1, wr1); end
        b1.resp_ready = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 302; i++) begin
            b1.req_valid = 1'b1;
            b1.req_write = (i >= 300) ? 1'b1 : 1'b0;
            b1.req_addr  = 5'(i % 32);
            b1.req_wdata = 13'h0123;
            @(negedge clk);
            b1.req_valid = 1'b0;
            lat = 0;
            while (b1.resp_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            if (lat != 1) n_bad++;
            @(negedge clk);
        end
        n_checks++; if (n_bad !== 0) begin n_fail++; $display("FAIL stats_latency bad=%0d exp 0", n_bad); end
        n_checks++; if (rd1 !== 8'hFF) begin n_fail++; $display("FAIL stats_rd_sat got %h exp ff", rd1); end
        n_checks++; if (wr1 !== 8'd2) begin n_fail++; $display("FAIL stats_wr got %h exp 02", wr1); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (rd1 !== 8'h00 || wr1 !== 8'h00) begin n_fail++; $display("FAIL stats_reset got rd=%h wr=%h exp 00 00", rd1, wr1); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_read_init();
        test_write_read();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
`ifdef MEM_RESPONDER_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
